// File: rtl/dnn_result_uart_tx.sv
// Captures DNN final-layer results after a warm-up strobe count, queues them in a FIFO
// and ships each result as two UART 8N1 bytes (upper byte first).
module dnn_result_uart_tx #(
    parameter int RESULT_W     = 10,
    parameter int SKIP_COUNT   = 12344,
    parameter int FIFO_DEPTH   = 256,
    parameter int CLKS_PER_BIT = 174
) (
    input  logic                clk_20,
    input  logic                rstn,
    input  logic                dnn_rst,
    input  logic                cycle_clk,
    input  logic [RESULT_W-1:0] act_in,
    output logic                uart_tx,
    output logic                tx_busy,
    output logic                fifo_empty,
    output logic                overflow,
    output logic [15:0]         output_count,
    output logic [15:0]         captured_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [16:0]   SKIP_L    = 17'(SKIP_COUNT);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP} state_t;

    logic [RESULT_W-1:0] mem [FIFO_DEPTH];
    logic [RESULT_W-1:0] dout_reg;
    logic [AW:0]         wr_ptr_reg, rd_ptr_reg;
    logic                fifo_empty_reg, overflow_reg;
    logic [15:0]         output_count_reg, captured_count_reg;
    logic                fifo_full, capture_en, wr_en, drop, rd_en;

    state_t        state_reg, state_next;
    logic [BW-1:0] baud_reg, baud_next;
    logic [2:0]    bit_reg, bit_next;
    logic          byte_sel_reg, byte_sel_next;
    logic [15:0]   word_reg, word_next;
    logic [7:0]    tx_byte_next;
    logic          uart_tx_reg, tx_next, baud_done;

    // Extra pointer MSB distinguishes full from empty when the low bits match.
    assign fifo_full  = (wr_ptr_reg[AW] != rd_ptr_reg[AW]) &&
                        (wr_ptr_reg[AW-1:0] == rd_ptr_reg[AW-1:0]);
    assign capture_en = cycle_clk && !dnn_rst && ({1'b0, output_count_reg} >= SKIP_L);
    assign wr_en      = capture_en && !fifo_full;
    assign drop       = capture_en && fifo_full;

    always_ff @(posedge clk_20) begin
        if (wr_en)
            mem[wr_ptr_reg[AW-1:0]] <= act_in;
        if (rd_en)
            dout_reg <= mem[rd_ptr_reg[AW-1:0]];
    end

    always_ff @(posedge clk_20 or negedge rstn) begin
        if (!rstn) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fifo_empty_reg     <= 1'b1;
            overflow_reg       <= 1'b0;
            output_count_reg   <= '0;
            captured_count_reg <= '0;
        end else if (dnn_rst) begin
            wr_ptr_reg         <= '0;
            rd_ptr_reg         <= '0;
            fifo_empty_reg     <= 1'b1;
            overflow_reg       <= 1'b0;
            output_count_reg   <= '0;
            captured_count_reg <= '0;
        end else begin
            if (cycle_clk && output_count_reg != 16'hFFFF)
                output_count_reg <= output_count_reg + 16'd1;
            if (wr_en) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
                if (captured_count_reg != 16'hFFFF)
                    captured_count_reg <= captured_count_reg + 16'd1;
            end
            if (drop)
                overflow_reg <= 1'b1;
            if (rd_en)
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            // Flag lags the pointers by one edge, giving the write-to-start latency of 3.
            fifo_empty_reg <= (wr_ptr_reg == rd_ptr_reg);
        end
    end

    assign baud_done = (baud_reg == BAUD_LAST);

    always_comb begin
        state_next    = state_reg;
        baud_next     = '0;
        bit_next      = bit_reg;
        byte_sel_next = byte_sel_reg;
        word_next     = word_reg;
        rd_en         = 1'b0;
        tx_next       = 1'b1;
        case (state_reg)
            IDLE: begin
                // No pop while clearing: the read would target a pointer being reset.
                if (!fifo_empty_reg && !dnn_rst) begin
                    rd_en         = 1'b1;
                    byte_sel_next = 1'b0;
                    state_next    = LOAD;
                end
            end
            LOAD: begin
                word_next  = 16'(dout_reg);
                bit_next   = '0;
                state_next = START;
            end
            START: begin
                if (baud_done) state_next = DATA;
                else           baud_next  = baud_reg + BW'(1);
            end
            DATA: begin
                if (baud_done) begin
                    if (bit_reg == 3'd7) state_next = STOP;
                    else                 bit_next   = bit_reg + 3'd1;
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            STOP: begin
                if (baud_done) begin
                    if (!byte_sel_reg) begin
                        byte_sel_next = 1'b1;
                        bit_next      = '0;
                        state_next    = START;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    baud_next = baud_reg + BW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
        tx_byte_next = byte_sel_next ? word_next[7:0] : word_next[15:8];
        case (state_next)
            START:   tx_next = 1'b0;
            DATA:    tx_next = tx_byte_next[bit_next];
            default: tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge clk_20 or negedge rstn) begin
        if (!rstn) begin
            state_reg    <= IDLE;
            baud_reg     <= '0;
            bit_reg      <= '0;
            byte_sel_reg <= 1'b0;
            word_reg     <= '0;
            uart_tx_reg  <= 1'b1;
        end else begin
            state_reg    <= state_next;
            baud_reg     <= baud_next;
            bit_reg      <= bit_next;
            byte_sel_reg <= byte_sel_next;
            word_reg     <= word_next;
            uart_tx_reg  <= tx_next;
        end
    end

    assign uart_tx        = uart_tx_reg;
    assign tx_busy        = (state_reg != IDLE);
    assign fifo_empty     = fifo_empty_reg;
    assign overflow       = overflow_reg;
    assign output_count   = output_count_reg;
    assign captured_count = captured_count_reg;

endmodule

// File: tb/tb_dnn_result_uart_tx.sv
// Scoreboard bench: stimulus pushes expected result words, a UART receiver pops and compares.
`timescale 1ns/1ps
module tb_dnn_result_uart_tx;

    localparam int CPB_A = 4;
    localparam int CPB_B = 174;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rstn_a, dnn_rst_a, cycle_clk_a;
    logic [9:0] act_a;
    logic       uart_tx_a, tx_busy_a, fifo_empty_a, overflow_a;
    logic [15:0] oc_a, cc_a;

    logic       rstn_b, dnn_rst_b, cycle_clk_b;
    logic [9:0] act_b;
    logic       uart_tx_b, tx_busy_b, fifo_empty_b, overflow_b;
    logic [15:0] oc_b, cc_b;

    dnn_result_uart_tx #(.RESULT_W(10), .SKIP_COUNT(2), .FIFO_DEPTH(4), .CLKS_PER_BIT(CPB_A)) dut_a (
        .clk_20(clk), .rstn(rstn_a), .dnn_rst(dnn_rst_a), .cycle_clk(cycle_clk_a), .act_in(act_a),
        .uart_tx(uart_tx_a), .tx_busy(tx_busy_a), .fifo_empty(fifo_empty_a), .overflow(overflow_a),
        .output_count(oc_a), .captured_count(cc_a)
    );

    dnn_result_uart_tx #(.RESULT_W(10), .SKIP_COUNT(12344), .FIFO_DEPTH(256), .CLKS_PER_BIT(CPB_B)) dut_b (
        .clk_20(clk), .rstn(rstn_b), .dnn_rst(dnn_rst_b), .cycle_clk(cycle_clk_b), .act_in(act_b),
        .uart_tx(uart_tx_b), .tx_busy(tx_busy_b), .fifo_empty(fifo_empty_b), .overflow(overflow_b),
        .output_count(oc_b), .captured_count(cc_b)
    );

    int compared = 0;
    int mismatched = 0;
    int cyc = 0;
    logic [15:0] exp_a[$];
    logic [15:0] exp_b[$];
    int start_a[$];
    int lowrun_b[$];
    int run_b;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // UART receiver state, one slot per DUT instance
    logic       rx_act[2];
    int         rx_cnt[2];
    logic [7:0] rx_sh[2];
    logic       rx_bi[2];
    logic [7:0] rx_b0[2];
    int         rx_st[2];

    task automatic rx_step(input int i, input logic line, input logic rn, input int cpb);
        logic [15:0] w;
        if (!rn) begin
            rx_act[i] = 1'b0;
            rx_bi[i]  = 1'b0;
        end else if (!rx_act[i]) begin
            if (line == 1'b0) begin
                rx_act[i] = 1'b1;
                rx_cnt[i] = 0;
                if (!rx_bi[i]) rx_st[i] = cyc;
            end
        end else begin
            rx_cnt[i]++;
            if (rx_cnt[i] == cpb / 2) begin
                check($sformatf("start_bit_dut%0d", i), 32'(line), 32'd0);
                if (line) rx_act[i] = 1'b0;
            end else if (rx_cnt[i] >= cpb && rx_cnt[i] < 9 * cpb && (rx_cnt[i] % cpb) == cpb / 2) begin
                rx_sh[i][rx_cnt[i] / cpb - 1] = line;
            end else if (rx_cnt[i] == 9 * cpb + cpb / 2) begin
                check($sformatf("stop_bit_dut%0d", i), 32'(line), 32'd1);
                rx_act[i] = 1'b0;
                if (!rx_bi[i]) begin
                    rx_b0[i] = rx_sh[i];
                    rx_bi[i] = 1'b1;
                end else begin
                    rx_bi[i] = 1'b0;
                    w = {rx_b0[i], rx_sh[i]};
                    $display("dut%0d rx word 0x%04h at cycle %0d", i, w, rx_st[i]);
                    if (i == 0) begin
                        start_a.push_back(rx_st[i]);
                        if (exp_a.size() == 0) begin
                            compared++; mismatched++;
                            $display("FAIL unexpected_word_a: got 0x%04h, expected none", w);
                        end else check("rx_word_a", 32'(w), 32'(exp_a.pop_front()));
                    end else begin
                        if (exp_b.size() == 0) begin
                            compared++; mismatched++;
                            $display("FAIL unexpected_word_b: got 0x%04h, expected none", w);
                        end else check("rx_word_b", 32'(w), 32'(exp_b.pop_front()));
                    end
                end
            end
        end
    endtask

    always @(negedge clk) begin
        rx_step(0, uart_tx_a, rstn_a, CPB_A);
        rx_step(1, uart_tx_b, rstn_b, CPB_B);
        if (!rstn_b) run_b = 0;
        else if (uart_tx_b == 1'b0) run_b++;
        else if (run_b > 0) begin
            lowrun_b.push_back(run_b);
            run_b = 0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic strobe_a(input logic [9:0] v);
        cycle_clk_a = 1'b1; act_a = v;
        tick(1);
        cycle_clk_a = 1'b0;
    endtask

    task automatic strobe_b(input logic [9:0] v);
        cycle_clk_b = 1'b1; act_b = v;
        tick(1);
        cycle_clk_b = 1'b0;
    endtask

    task automatic wait_until_cyc(input int n);
        while (cyc < n) tick(1);
    endtask

    task automatic wait_drain_a(input int limit);
        for (int k = 0; k < limit && exp_a.size() != 0; k++) tick(1);
        check("drain_a", 32'(exp_a.size()), 32'd0);
    endtask

    task automatic wait_idle_a(input int limit);
        for (int k = 0; k < limit && tx_busy_a; k++) tick(1);
        check("idle_a", 32'(tx_busy_a), 32'd0);
    endtask

    int c, ts;

    initial begin
        rstn_a = 0; dnn_rst_a = 0; cycle_clk_a = 0; act_a = '0;
        rstn_b = 0; dnn_rst_b = 0; cycle_clk_b = 0; act_b = '0;
        tick(3);
        check("rst_uart", 32'(uart_tx_a), 32'd1);
        check("rst_busy", 32'(tx_busy_a), 32'd0);
        check("rst_empty", 32'(fifo_empty_a), 32'd1);
        check("rst_overflow", 32'(overflow_a), 32'd0);
        check("rst_oc", 32'(oc_a), 32'd0);
        check("rst_cc", 32'(cc_a), 32'd0);
        rstn_a = 1; rstn_b = 1;
        tick(1);

        // 1: warm-up skip, single result, latency
        strobe_a(10'h111);
        strobe_a(10'h222);
        exp_a.push_back(16'h03A5);
        strobe_a(10'h3A5);
        c = cyc;
        check("t1_oc", 32'(oc_a), 32'd3);
        check("t1_cc", 32'(cc_a), 32'd1);
        wait_drain_a(200);
        check("t1_start_seen", 32'(start_a.size()), 32'd1);
        if (start_a.size() > 0) check("t1_latency", 32'(start_a[0] - c), 32'd3);
        wait_idle_a(50);

        // 2: overflow with back-to-back strobes, inter-word gap
        start_a.delete();
        dnn_rst_a = 1; tick(1); dnn_rst_a = 0;
        strobe_a(10'h000);
        strobe_a(10'h000);
        for (int v = 1; v <= 6; v++) begin
            if (v <= 5) exp_a.push_back(16'(v));
            strobe_a(10'(v));
        end
        check("t2_overflow", 32'(overflow_a), 32'd1);
        check("t2_cc", 32'(cc_a), 32'd5);
        check("t2_oc", 32'(oc_a), 32'd8);
        wait_drain_a(1000);
        check("t2_words", 32'(start_a.size()), 32'd5);
        for (int j = 1; j < start_a.size(); j++)
            check("t2_gap", 32'(start_a[j] - start_a[j-1]), 32'(20 * CPB_A + 2));
        wait_idle_a(50);

        // 3: dnn_rst mid-word with two words queued
        exp_a.push_back(16'h0155);
        strobe_a(10'h155);
        c = cyc;
        strobe_a(10'h2AA);
        strobe_a(10'h0F0);
        check("t3_cc_pre", 32'(cc_a), 32'd8);
        ts = c + 3;
        wait_until_cyc(ts + 16);
        dnn_rst_a = 1; tick(1); dnn_rst_a = 0;
        check("t3_oc", 32'(oc_a), 32'd0);
        check("t3_cc", 32'(cc_a), 32'd0);
        check("t3_overflow", 32'(overflow_a), 32'd0);
        check("t3_busy_mid", 32'(tx_busy_a), 32'd1);
        wait_until_cyc(ts + 20 * CPB_A - 1);
        check("t3_busy_last", 32'(tx_busy_a), 32'd1);
        tick(1);
        check("t3_busy_fall", 32'(tx_busy_a), 32'd0);
        tick(40);
        check("t3_empty", 32'(fifo_empty_a), 32'd1);
        check("t3_uart_idle", 32'(uart_tx_a), 32'd1);
        check("t3_busy_after", 32'(tx_busy_a), 32'd0);
        check("t3_drain", 32'(exp_a.size()), 32'd0);

        // 4: dnn_rst coincident with cycle_clk
        strobe_a(10'h000);
        strobe_a(10'h000);
        check("t4_oc_pre", 32'(oc_a), 32'd2);
        dnn_rst_a = 1; cycle_clk_a = 1; act_a = 10'h3FF;
        tick(1);
        dnn_rst_a = 0; cycle_clk_a = 0;
        check("t4_oc", 32'(oc_a), 32'd0);
        check("t4_cc", 32'(cc_a), 32'd0);
        tick(10);
        check("t4_empty", 32'(fifo_empty_a), 32'd1);
        check("t4_uart", 32'(uart_tx_a), 32'd1);
        check("t4_busy", 32'(tx_busy_a), 32'd0);

        // 5: asynchronous rstn mid-DATA, then normal operation
        strobe_a(10'h000);
        strobe_a(10'h000);
        strobe_a(10'h2C3);
        c = cyc;
        wait_until_cyc(c + 3 + CPB_A + 1);
        check("t5_uart_low", 32'(uart_tx_a), 32'd0);
        check("t5_busy_pre", 32'(tx_busy_a), 32'd1);
        #2 rstn_a = 0;
        #1;
        check("t5_uart", 32'(uart_tx_a), 32'd1);
        check("t5_busy", 32'(tx_busy_a), 32'd0);
        check("t5_oc", 32'(oc_a), 32'd0);
        check("t5_cc", 32'(cc_a), 32'd0);
        check("t5_empty", 32'(fifo_empty_a), 32'd1);
        tick(2);
        rstn_a = 1;
        tick(1);
        strobe_a(10'h000);
        strobe_a(10'h000);
        exp_a.push_back(16'h02C3);
        strobe_a(10'h2C3);
        wait_drain_a(200);
        wait_idle_a(50);

        // 6: default parameters, full warm-up
        exp_b.push_back(16'h0038);
        for (int i = 0; i < 12544; i++) strobe_b(10'(i));
        check("t6_oc", 32'(oc_b), 32'd12544);
        check("t6_cc", 32'(cc_b), 32'd200);
        check("t6_overflow", 32'(overflow_b), 32'd0);
        for (int k = 0; k < 4000 && exp_b.size() != 0; k++) tick(1);
        check("drain_b", 32'(exp_b.size()), 32'd0);
        rstn_b = 0;
        check("t6_runs", 32'(lowrun_b.size() >= 2), 32'd1);
        if (lowrun_b.size() >= 2) begin
            check("t6_run_byte0", 32'(lowrun_b[0]), 32'(9 * CPB_B));
            check("t6_run_byte1", 32'(lowrun_b[1]), 32'(4 * CPB_B));
        end
        tick(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
